snoop_bus_arbiter: RTL

Round-robin arbiter and transaction sequencer for the common snoop bus shared by the four cores' data-cache controllers. It grants one requester at a time and drives BusRd/BusRdX/Invalidate and Address_Com for exactly one snoop cycle. It collects the other caches' Shared/Modified responses, then sequences the data phase: memory read, or cache-to-cache flush from an M holder. It reports completion, the Shared result and an error flag back to the requester.

---
 rtl/snoop_bus_arbiter_pkg.sv | 27 ++
 rtl/rr_arbiter4.sv | 30 +++
 rtl/snoop_bus_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_arbiter_pkg.sv
// Snoop bus arbiter shared definitions.
// Command and state encodings plus small helpers.
package snoop_bus_arbiter_pkg;

   localparam int NUM_CORES = 4;

   typedef enum logic [1:0] {
      CMD_ILL = 2'b00,
      CMD_RD  = 2'b01,
      CMD_RDX = 2'b10,
      CMD_INV = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNOOP,
      ST_MEM,
      ST_FLUSH,
      ST_DONE
   } state_e;

   // true when more than one bit of v is set
   function automatic logic multi_hot(input logic [3:0] v);
      return |(v & (v - 4'd1));
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin pick.
// First set request at or above ptr, wrapping.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic [1:0] idx,
   output logic       valid
);

   logic [7:0] dbl;
   logic [3:0] rot;

   // rotate requests so ptr sits at bit 0, then take the lowest
   always_comb begin
      dbl   = {req, req} >> ptr;
      rot   = dbl[3:0];
      valid = |req;
      idx   = ptr;
      priority case (1'b1)
         rot[0]:  idx = ptr;
         rot[1]:  idx = ptr + 2'd1;
         rot[2]:  idx = ptr + 2'd2;
         rot[3]:  idx = ptr + 2'd3;
         default: idx = ptr;
      endcase
      grant = valid ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter and transaction sequencer.
// Grants one core, snoops, then runs the memory or flush phase.
module snoop_bus_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 32,
   parameter int TIMEOUT   = 255,
   parameter int CNT_W     = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [2*NUM_CORES-1:0]      cmd,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES-1:0]        snoop_shared,
   input  logic [NUM_CORES-1:0]        snoop_modified,
   input  logic                        flush_done,
   input  logic                        mem_ack,
   output logic [NUM_CORES-1:0]        gnt,
   output logic                        BusRd,
   output logic                        BusRdX,
   output logic                        Invalidate,
   output logic [ADDR_W-1:0]           Address_Com,
   output logic                        Shared,
   output logic                        mem_rd_req,
   output logic [NUM_CORES-1:0]        done,
   output logic                        err
);
   import snoop_bus_arbiter_pkg::*;

   state_e             state;
   state_e             state_nxt;
   logic [1:0]         ptr;
   logic [1:0]         owner;
   logic [3:0]         own_q;
   cmd_e               cmd_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               err_q;
   logic               shared_q;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         arb_gnt;
   logic [1:0]         arb_idx;
   logic               arb_valid;
   cmd_e               req_cmd;
   logic [3:0]         s_other;
   logic [3:0]         m_other;
   logic               cnt_hit;

   rr_arbiter4 u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign req_cmd = cmd_e'(cmd[arb_idx*2 +: 2]);
   assign s_other = snoop_shared & ~own_q;
   assign m_other = snoop_modified & ~own_q;
   assign cnt_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign Shared  = shared_q;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next state and outputs decoded from registered state
   always_comb begin
      state_nxt   = state;
      gnt         = '0;
      BusRd       = 1'b0;
      BusRdX      = 1'b0;
      Invalidate  = 1'b0;
      Address_Com = '0;
      mem_rd_req  = 1'b0;
      done        = '0;
      err         = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (arb_valid)
               state_nxt = (req_cmd == CMD_ILL) ? ST_DONE : ST_SNOOP;
         end
         ST_SNOOP: begin
            gnt         = own_q;
            Address_Com = addr_q;
            BusRd       = (cmd_q == CMD_RD);
            BusRdX      = (cmd_q == CMD_RDX);
            Invalidate  = (cmd_q == CMD_INV);
            if (cmd_q == CMD_INV) state_nxt = ST_DONE;
            else if (|m_other)    state_nxt = ST_FLUSH;
            else                  state_nxt = ST_MEM;
         end
         ST_MEM: begin
            gnt         = own_q;
            Address_Com = addr_q;
            mem_rd_req  = 1'b1;
            if (mem_ack || cnt_hit) state_nxt = ST_DONE;
         end
         ST_FLUSH: begin
            gnt         = own_q;
            Address_Com = addr_q;
            if (flush_done || cnt_hit) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            gnt         = own_q;
            Address_Com = addr_q;
            done        = own_q;
            err         = err_q;
            state_nxt   = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // owner latches, snoop result, timeout counter and rr pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         owner    <= '0;
         own_q    <= '0;
         cmd_q    <= CMD_ILL;
         addr_q   <= '0;
         err_q    <= 1'b0;
         shared_q <= 1'b0;
         cnt      <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  own_q    <= arb_gnt;
                  owner    <= arb_idx;
                  cmd_q    <= req_cmd;
                  addr_q   <= addr[arb_idx*ADDR_W +: ADDR_W];
                  err_q    <= (req_cmd == CMD_ILL);
                  shared_q <= 1'b0;
                  cnt      <= '0;
               end
            end
            ST_SNOOP: begin
               shared_q <= |s_other;
               if (cmd_q != CMD_INV && multi_hot(m_other))
                  err_q <= 1'b1;
            end
            ST_MEM: begin
               cnt <= cnt + CNT_W'(1);
               if (!mem_ack && cnt_hit) err_q <= 1'b1;
            end
            ST_FLUSH: begin
               cnt <= cnt + CNT_W'(1);
               if (!flush_done && cnt_hit) err_q <= 1'b1;
            end
            ST_DONE: begin
               ptr      <= owner + 2'd1;
               cnt      <= '0;
               shared_q <= 1'b0;
               err_q    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
